lock_input_cond: RTL and testbench

- Input conditioner directly upstream of the digital-lock core; consumes the raw pad-level enter button and the 4-bit digit switches.
- Synchronizes and debounces both inputs.
- Delivers to the lock core a single-cycle enter strobe and a digit bus guaranteed stable around that strobe.
- Guarantees switch bounce or reset-time button state never produces a spurious or duplicate code entry.

---
 rtl/lock_input_cond.sv | 227 ++++++++++++++++++++++
 tb/tb_lock_input_cond.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_input_cond.sv
// ---------------------------------------------------------------------------
// lock_input_cond
//
// Input conditioner that sits directly in front of the digital-lock core.
// It synchronizes and debounces the raw enter button and the 4-bit digit
// switches. It then hands the core two things:
//   * a single-cycle enter strobe;
//   * a digit bus that is guaranteed stable around that strobe.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   enter_raw    in   1  raw enter button (asynchronous to clk)
//   digit_raw    in   4  raw digit switches (asynchronous to clk)
//   enter_pulse  out  1  one-cycle accepted-entry strobe
//   digit_out    out  4  debounced digit, frozen while the button is held
//   digit_valid  out  1  digit bus stable for >= DEBOUNCE_CYCLES cycles
//   reject_cnt   out  8  rejected-press counter (only with the macro below)
//
// Optional feature macro: LOCK_INPUT_REJECT_CNT_EN
//   When defined, the reject_cnt port and its saturating counter exist.
//   A press is rejected when the button is accepted while the digit is not
//   yet valid. When undefined, rejected presses are silently dropped.
// ---------------------------------------------------------------------------
module lock_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_raw,
    input  logic [3:0] digit_raw,
    output logic       enter_pulse,
    output logic [3:0] digit_out,
    output logic       digit_valid
`ifdef LOCK_INPUT_REJECT_CNT_EN
    ,
    output logic [7:0] reject_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // Synchronizer chains; the last stage is the only copy used downstream.
    logic [SYNC_STAGES-1:0]      enter_sync_q;
    logic [SYNC_STAGES-1:0][3:0] digit_sync_q;
    logic                        enter_sync_s;
    logic [3:0]                  digit_sync_s;

    // Enter debounce state.
    logic [CNT_W-1:0] enter_cnt_q, enter_cnt_d;
    logic             enter_db_q,  enter_db_d;

    // Digit debounce state.
    logic [3:0]       dig_cand_q,    dig_cand_d;
    logic [CNT_W-1:0] dig_cnt_q,     dig_cnt_d;
    logic             digit_valid_q, digit_valid_d;

    // FSM and registered outputs.
    state_t     state_q, state_d;
    logic       enter_pulse_q, enter_pulse_d;
    logic [3:0] digit_out_q,   digit_out_d;

    assign enter_sync_s = enter_sync_q[SYNC_STAGES-1];
    assign digit_sync_s = digit_sync_q[SYNC_STAGES-1];

    // Synchronizer shift registers for the button and every digit bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_sync_q <= '0;
            digit_sync_q <= '0;
        end else begin
            enter_sync_q <= {enter_sync_q[SYNC_STAGES-2:0], enter_raw};
            digit_sync_q <= {digit_sync_q[SYNC_STAGES-2:0], digit_raw};
        end
    end

    // Enter debounce: the accepted level flips only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement. Any agreement restarts the count.
    always_comb begin
        enter_cnt_d = enter_cnt_q;
        enter_db_d  = enter_db_q;
        if (enter_sync_s == enter_db_q) begin
            enter_cnt_d = '0;
        end else if (enter_cnt_q == DEB_LAST) begin
            enter_db_d  = ~enter_db_q;
            enter_cnt_d = '0;
        end else begin
            enter_cnt_d = enter_cnt_q + CNT_ONE;
        end
    end

    // Digit debounce: the bus is treated as one value. Any change restarts
    // the stability window. Valid is asserted when the counter saturates.
    always_comb begin
        dig_cand_d    = dig_cand_q;
        dig_cnt_d     = dig_cnt_q;
        digit_valid_d = digit_valid_q;
        if (digit_sync_s != dig_cand_q) begin
            dig_cand_d    = digit_sync_s;
            dig_cnt_d     = '0;
            digit_valid_d = 1'b0;
        end else begin
            if (dig_cnt_q != DEB_MAX) begin
                dig_cnt_d = dig_cnt_q + CNT_ONE;
            end else begin
                dig_cnt_d = dig_cnt_q;
            end
            digit_valid_d = (dig_cnt_d == DEB_MAX);
        end
    end

    // FSM next-state logic: follows the debounced button level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_db_q) begin
                    state_d = ST_PRESSED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (!enter_db_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            default: state_d = ST_PRESSED;
        endcase
    end

    // FSM output logic.
    // A press pulses only if the digit was already valid.
    // digit_out tracks the candidate only in IDLE, and only when no press is
    // accepted on the same edge, so the freeze wins on simultaneous events.
    always_comb begin
        enter_pulse_d = 1'b0;
        digit_out_d   = digit_out_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_db_q) begin
                    enter_pulse_d = digit_valid_q;
                end else if (digit_valid_q) begin
                    digit_out_d = dig_cand_q;
                end else begin
                    digit_out_d = digit_out_q;
                end
            end
            ST_PRESSED: begin
                digit_out_d = digit_out_q;
            end
            default: begin
                enter_pulse_d = 1'b0;
                digit_out_d   = digit_out_q;
            end
        endcase
    end

    // State, debounce and output registers.
    // Reset parks the FSM in PRESSED with the button seen as pressed, so a
    // button held through reset must first be released before it can count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_cnt_q   <= '0;
            enter_db_q    <= 1'b1;
            dig_cand_q    <= 4'h0;
            dig_cnt_q     <= '0;
            digit_valid_q <= 1'b0;
            state_q       <= ST_PRESSED;
            enter_pulse_q <= 1'b0;
            digit_out_q   <= 4'h0;
        end else begin
            enter_cnt_q   <= enter_cnt_d;
            enter_db_q    <= enter_db_d;
            dig_cand_q    <= dig_cand_d;
            dig_cnt_q     <= dig_cnt_d;
            digit_valid_q <= digit_valid_d;
            state_q       <= state_d;
            enter_pulse_q <= enter_pulse_d;
            digit_out_q   <= digit_out_d;
        end
    end

    assign enter_pulse = enter_pulse_q;
    assign digit_out   = digit_out_q;
    assign digit_valid = digit_valid_q;

`ifdef LOCK_INPUT_REJECT_CNT_EN
    logic       reject_s;
    logic [7:0] reject_cnt_q, reject_cnt_d;

    assign reject_s = (state_q == ST_IDLE) && enter_db_q && !digit_valid_q;

    // Saturating count of presses accepted while the digit was unstable.
    always_comb begin
        reject_cnt_d = reject_cnt_q;
        if (reject_s && (reject_cnt_q != 8'hFF)) begin
            reject_cnt_d = reject_cnt_q + 8'h01;
        end else begin
            reject_cnt_d = reject_cnt_q;
        end
    end

    // Reject counter register; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reject_cnt_q <= 8'h00;
        end else begin
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: tb/tb_lock_input_cond.sv
module tb_lock_input_cond;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_raw;
    logic [3:0] digit_raw;
    logic       enter_pulse;
    logic [3:0] digit_out;
    logic       digit_valid;
`ifdef LOCK_INPUT_REJECT_CNT_EN
    logic [7:0] reject_cnt;
`endif

    lock_input_cond #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enter_raw  (enter_raw),
        .digit_raw  (digit_raw),
        .enter_pulse(enter_pulse),
        .digit_out  (digit_out),
        .digit_valid(digit_valid)
`ifdef LOCK_INPUT_REJECT_CNT_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One record = inputs held for 'reps' edges, with outputs expected
    // after each of those edges.
    typedef struct {
        logic       enter;
        logic [3:0] digit;
        int         reps;
        logic       pulse;
        logic [3:0] dout;
        logic       valid;
    } vec_t;

    vec_t vecs [11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (enter_pulse === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int lat;
        int found;

        // Sequence from reset release with enter=0, digit=7.
        // Edge numbering starts at the first edge after reset release.
        vecs[0]  = '{1'b0, 4'h7, 6, 1'b0, 4'h0, 1'b0}; // edges 1-6: digit not yet stable
        vecs[1]  = '{1'b0, 4'h7, 1, 1'b0, 4'h0, 1'b1}; // edge 7: valid
        vecs[2]  = '{1'b0, 4'h7, 3, 1'b0, 4'h7, 1'b1}; // edges 8-10: digit_out loads
        vecs[3]  = '{1'b1, 4'h7, 6, 1'b0, 4'h7, 1'b1}; // press, edges 1-6 of press
        vecs[4]  = '{1'b1, 4'h7, 1, 1'b1, 4'h7, 1'b1}; // press edge 7: strobe
        vecs[5]  = '{1'b1, 4'h7, 1, 1'b0, 4'h7, 1'b1}; // strobe is one cycle
        vecs[6]  = '{1'b1, 4'h2, 2, 1'b0, 4'h7, 1'b1}; // digit moves while pressed
        vecs[7]  = '{1'b1, 4'h2, 4, 1'b0, 4'h7, 1'b0}; // candidate changed, invalid
        vecs[8]  = '{1'b1, 4'h2, 2, 1'b0, 4'h7, 1'b1}; // valid again, still frozen
        vecs[9]  = '{1'b0, 4'h2, 7, 1'b0, 4'h7, 1'b1}; // release; IDLE after 7th edge
        vecs[10] = '{1'b0, 4'h2, 4, 1'b0, 4'h2, 1'b1}; // loads on first IDLE cycle

        // Reset values, asynchronously visible before any clock edge.
        reset     = 1'b1;
        enter_raw = 1'b0;
        digit_raw = 4'h7;
        #1;
        check("rst_pulse", {7'd0, enter_pulse}, 8'h00);
        check("rst_dout",  {4'd0, digit_out},   8'h00);
        check("rst_valid", {7'd0, digit_valid}, 8'h00);
`ifdef LOCK_INPUT_REJECT_CNT_EN
        check("rst_reject", reject_cnt, 8'h00);
`endif
        step();
        step();
        reset = 1'b0;

        // Table-driven main sequence.
        for (int k = 0; k < 11; k++) begin
            enter_raw = vecs[k].enter;
            digit_raw = vecs[k].digit;
            for (int r = 0; r < vecs[k].reps; r++) begin
                step();
                check($sformatf("tbl%0d.%0d_pulse", k, r), {7'd0, enter_pulse}, {7'd0, vecs[k].pulse});
                check($sformatf("tbl%0d.%0d_dout", k, r),  {4'd0, digit_out},   {4'd0, vecs[k].dout});
                check($sformatf("tbl%0d.%0d_valid", k, r), {7'd0, digit_valid}, {7'd0, vecs[k].valid});
            end
        end

        // Reject: the digit change lands two cycles before the debounced
        // enter edge, so the digit is invalid when the press is accepted.
        digit_raw = 4'h3;
        run(10, pulses);
        check("rej_pre_dout",  {4'd0, digit_out},   8'h03);
        check("rej_pre_valid", {7'd0, digit_valid}, 8'h01);
        enter_raw = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) digit_raw = 4'h9;
            step();
            if (enter_pulse === 1'b1) pulses++;
        end
        check("rej_no_pulse", pulses[7:0], 8'h00);
        check("rej_dout_frozen", {4'd0, digit_out}, 8'h03);
        check("rej_valid_after", {7'd0, digit_valid}, 8'h01);
`ifdef LOCK_INPUT_REJECT_CNT_EN
        check("rej_cnt", reject_cnt, 8'h01);
`endif
        enter_raw = 1'b0;
        run(12, pulses);
        check("rej_release_pulse", pulses[7:0], 8'h00);
        check("rej_dout_new", {4'd0, digit_out}, 8'h09);

        // Bounce shorter than the debounce window, then a clean hold.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            enter_raw = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step();
            if (enter_pulse === 1'b1) pulses++;
        end
        check("bounce_no_pulse", pulses[7:0], 8'h00);
        enter_raw = 1'b1;
        run(20, pulses);
        check("bounce_one_pulse", pulses[7:0], 8'h01);
        enter_raw = 1'b0;
        run(12, pulses);
        check("bounce_release", pulses[7:0], 8'h00);

        // Button held through reset must be seen released first.
        enter_raw = 1'b1;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
`ifdef LOCK_INPUT_REJECT_CNT_EN
        check("held_rst_reject", reject_cnt, 8'h00);
`endif
        run(30, pulses);
        check("held_no_pulse", pulses[7:0], 8'h00);
        enter_raw = 1'b0;
        run(10, pulses);
        check("held_release", pulses[7:0], 8'h00);
        enter_raw = 1'b1;
        run(20, pulses);
        check("held_new_press", pulses[7:0], 8'h01);
        enter_raw = 1'b0;
        run(12, pulses);

        // Latency of a clean press, then reset while the strobe is high.
        enter_raw = 1'b1;
        found = 0;
        lat   = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            lat = i + 1;
            if (enter_pulse === 1'b1) found = 1;
        end
        check("mid_pulse_seen", found[7:0], 8'h01);
        check("mid_latency", lat[7:0], 8'd7);
        check("mid_dout_pre", {4'd0, digit_out}, 8'h09);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_pulse", {7'd0, enter_pulse}, 8'h00);
        check("mid_async_dout",  {4'd0, digit_out},   8'h00);
        check("mid_async_valid", {7'd0, digit_valid}, 8'h00);
        step();
        step();
        reset = 1'b0;
        run(30, pulses);
        check("mid_no_pulse_after", pulses[7:0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
